window_line_buffer: RTL and testbench

- Turns the tagged pixel stream `{tag, pixel}` produced by the word unpacker in the filter top into 3x3 neighbourhood windows, one window per image pixel, in raster order.
- Holds the two previous image rows in line memories, so downstream kernel arithmetic sees a complete window each cycle.
- Sits directly downstream of the unpacker and upstream of the kernel arithmetic; it replaces the raw pixel path into the filter unit.

---
 rtl/filter_pkg.sv | 32 +++
 rtl/line_ram.sv | 48 ++++
 rtl/window_line_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_window_line_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared tag codes, FSM states and window helpers for the filter path
//
// Purpose: constants shared by the window line buffer and its line memories.
//   - tag codes carried alongside each pixel in the unpacked stream
//   - state encoding of the window line buffer
//   - counter widths and the window byte-index helper
package filter_pkg;

  localparam int TAG_W      = 2;
  localparam int CNT_W      = 20;  // accepted/emitted pixel counters
  localparam int IMG_W_BITS = 10;  // image_width port width

  localparam logic [TAG_W-1:0] INVALID_TAG  = 2'd0;
  localparam logic [TAG_W-1:0] DATA_TAG0    = 2'd1;
  localparam logic [TAG_W-1:0] DATA_TAG1    = 2'd2;
  localparam logic [TAG_W-1:0] DATA_END_TAG = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Byte position of (row, column) inside the 72-bit window; row 0 is the
  // row above the centre, column 0 is the left neighbour.
  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - circular 8-bit line memory with wrap at a run-time width
//
// Purpose: delays a byte stream by exactly one image row. The read returns
// the byte written W writes ago at the current pointer, then the new byte
// overwrites it on the clock edge.
// Ports:
//   clock      system clock
//   clear      synchronous pointer clear (contents are kept)
//   wrap_addr  last pointer value before wrapping to 0 (W-1)
//   we         advance: write din at the pointer and step the pointer
//   din        byte to store
//   dout       byte stored one row earlier at the current pointer
module line_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic [AW-1:0] wrap_addr,
  input  logic          we,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Read-before-write: the old row's byte is visible in the same cycle the
  // new byte is presented.
  assign dout  = mem_q[ptr_q];
  assign ptr_d = (ptr_q == wrap_addr) ? '0 : ptr_q + AW'(1);

  always_ff @(posedge clock) begin
    if (clear) begin
      ptr_q <= '0;
    end else if (we) begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - 3x3 neighbourhood window generator over a tagged pixel stream
//
// Purpose: converts the unpacked {tag, pixel} stream into one 3x3 window per
// image pixel in raster order, with out-of-image neighbours forced to zero.
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   reflesh      synchronous restart for a new image (same effect as reset)
//   image_width  pixels per row, latched on the first accepted pixel
//   data_in      [8+:TAG_WIDTH] tag, [7:0] pixel
//   window_out   byte 3*r+c = row r (0 = above), column c (0 = left)
//   tag_out      tag of the emitted window, END once after the last window
//   busy         high while flushing the final row
module window_line_buffer
  import filter_pkg::*;
#(
  parameter int unsigned           TAG_WIDTH    = filter_pkg::TAG_W,
  parameter int unsigned           MAX_WIDTH    = 1024,
  parameter logic [TAG_WIDTH-1:0]  INVALID_TAG  = filter_pkg::INVALID_TAG,
  parameter logic [TAG_WIDTH-1:0]  DATA_TAG0    = filter_pkg::DATA_TAG0,
  parameter logic [TAG_WIDTH-1:0]  DATA_TAG1    = filter_pkg::DATA_TAG1,
  parameter logic [TAG_WIDTH-1:0]  DATA_END_TAG = filter_pkg::DATA_END_TAG
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reflesh,
  input  logic [IMG_W_BITS-1:0]   image_width,
  input  logic [8+TAG_WIDTH-1:0]  data_in,
  output logic [71:0]             window_out,
  output logic [TAG_WIDTH-1:0]    tag_out,
  output logic                    busy
);

  localparam int unsigned AW = $clog2(MAX_WIDTH);

  logic                   clr;
  logic [7:0]             pix_in;
  logic [TAG_WIDTH-1:0]   tag_in;

  state_e                 state_q;
  logic [IMG_W_BITS-1:0]  width_q;
  logic [IMG_W_BITS-1:0]  width_eff;
  logic [IMG_W_BITS-1:0]  last_col;
  logic [CNT_W-1:0]       acc_q;    // real pixels accepted (N)
  logic [CNT_W-1:0]       emit_q;   // windows emitted so far
  logic [CNT_W-1:0]       idx_q;    // linear index of the next pixel, real or synthetic
  logic [IMG_W_BITS-1:0]  cx_q;     // centre column of the next window
  logic [IMG_W_BITS-1:0]  cy_q;     // centre row of the next window
  logic [23:0]            col_q [3];
  logic [23:0]            col_d;
  logic                   mask_l_q;
  logic                   mask_r_q;
  logic                   mask_t_q;
  logic                   mask_b_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   end_pend_q;

  logic                   in_valid;
  logic                   accept;
  logic                   inject;
  logic                   step;
  logic                   emit;
  logic                   flush_done;
  logic [7:0]             pix_new;
  logic [7:0]             tap_above;
  logic [7:0]             tap_above2;
  logic [AW-1:0]          wrap_addr;

  assign clr    = reset | reflesh;
  assign pix_in = data_in[7:0];
  assign tag_in = data_in[8 +: TAG_WIDTH];

  assign in_valid = (tag_in == DATA_TAG0) || (tag_in == DATA_TAG1);
  assign accept   = in_valid &&
                    ((state_q == ST_IDLE) || (state_q == ST_FILL) || (state_q == ST_RUN));
  // Synthetic zero pixels keep the pipeline moving until every accepted
  // pixel has been emitted as a window centre.
  assign inject   = (state_q == ST_FLUSH) && (emit_q != acc_q);
  assign step     = accept || inject;

  // Width is not latched yet on the very first pixel, so the line memories
  // use the live port value for that one write.
  assign width_eff = (state_q == ST_IDLE) ? image_width : width_q;
  assign last_col  = width_q - IMG_W_BITS'(1);
  assign wrap_addr = AW'(width_eff - IMG_W_BITS'(1));

  // Pixel i emits centre i-W-1 once i >= W+1. While streaming, RUN already
  // encodes that; during flush the index is compared directly.
  assign emit = (accept && (state_q == ST_RUN)) ||
                (inject && (idx_q > CNT_W'(width_q)));

  assign flush_done = emit ? (emit_q + CNT_W'(1) == acc_q) : (emit_q == acc_q);

  assign pix_new = (state_q == ST_FLUSH) ? 8'h00 : pix_in;
  // New column: byte 0 = two rows up, byte 1 = one row up, byte 2 = current.
  assign col_d   = {pix_new, tap_above, tap_above2};

  line_ram #(.DEPTH(MAX_WIDTH)) u_ram_above (
    .clock     (clock),
    .clear     (clr),
    .wrap_addr (wrap_addr),
    .we        (step),
    .din       (pix_new),
    .dout      (tap_above)
  );

  // Fed by the first memory, so it yields the pixel two rows back.
  line_ram #(.DEPTH(MAX_WIDTH)) u_ram_above2 (
    .clock     (clock),
    .clear     (clr),
    .wrap_addr (wrap_addr),
    .we        (step),
    .din       (tap_above),
    .dout      (tap_above2)
  );

  always_ff @(posedge clock) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      width_q    <= '0;
      acc_q      <= '0;
      emit_q     <= '0;
      idx_q      <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      col_q[0]   <= '0;
      col_q[1]   <= '0;
      col_q[2]   <= '0;
      mask_l_q   <= 1'b0;
      mask_r_q   <= 1'b0;
      mask_t_q   <= 1'b0;
      mask_b_q   <= 1'b0;
      tag_q      <= INVALID_TAG;
      end_pend_q <= 1'b0;
    end else begin
      tag_q <= INVALID_TAG;

      if (step) begin
        col_q[0] <= col_q[1];
        col_q[1] <= col_q[2];
        col_q[2] <= col_d;
        idx_q    <= idx_q + CNT_W'(1);
      end

      if (accept) begin
        acc_q <= acc_q + CNT_W'(1);
      end

      if (emit) begin
        mask_l_q <= (cx_q == '0);
        mask_r_q <= (cx_q == last_col);
        mask_t_q <= (cy_q == '0);
        // Bottom row is synthetic once the pixel below the centre lies past N.
        mask_b_q <= (state_q == ST_FLUSH) && (idx_q > acc_q);
        tag_q    <= (cx_q == last_col) ? DATA_TAG1 : DATA_TAG0;
        emit_q   <= emit_q + CNT_W'(1);
        if (cx_q == last_col) begin
          cx_q <= '0;
          cy_q <= cy_q + IMG_W_BITS'(1);
        end else begin
          cx_q <= cx_q + IMG_W_BITS'(1);
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            width_q <= image_width;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (tag_in == DATA_END_TAG) begin
            state_q <= ST_FLUSH;
          end else if (accept && (acc_q == CNT_W'(width_q))) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tag_in == DATA_END_TAG) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_done) begin
            state_q    <= ST_DONE;
            end_pend_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (end_pend_q) begin
            tag_q      <= DATA_END_TAG;
            end_pend_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The column registers hold the full window after each step; the masks
  // captured at emission blank the neighbours that fall outside the image.
  always_comb begin
    window_out = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!((c == 0 && mask_l_q) || (c == 2 && mask_r_q) ||
              (r == 0 && mask_t_q) || (r == 2 && mask_b_q))) begin
          window_out[8*win_idx(r, c) +: 8] = col_q[c][8*r +: 8];
        end
      end
    end
  end

  assign tag_out = tag_q;
  assign busy    = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_window_line_buffer.sv
// tb/tb_window_line_buffer.sv - self-checking bench for window_line_buffer
module tb_window_line_buffer;
  import filter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        reflesh;
  logic [9:0]  image_width;
  logic [9:0]  data_in;
  logic [71:0] window_out;
  logic [1:0]  tag_out;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int last_busy;

  logic [7:0]  img [0:255];
  logic [71:0] cap_win [$];
  logic [1:0]  cap_tag [$];
  logic [71:0] ref_win [$];

  always #5 clock = ~clock;

  window_line_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .reflesh     (reflesh),
    .image_width (image_width),
    .data_in     (data_in),
    .window_out  (window_out),
    .tag_out     (tag_out),
    .busy        (busy)
  );

  task automatic check(input string nm, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [7:0] p);
    data_in = {t, p};
    tick();
  endtask

  task automatic pulse_reflesh();
    reflesh = 1'b1;
    drive(INVALID_TAG, 8'h00);
    reflesh = 1'b0;
  endtask

  function automatic logic [71:0] pack9(input int b0, input int b1, input int b2,
                                        input int b3, input int b4, input int b5,
                                        input int b6, input int b7, input int b8);
    return {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  // Reference window: neighbours inside the W x (N/W) image, zero elsewhere.
  function automatic logic [71:0] model_win(input int c, input int w, input int n);
    logic [71:0] res;
    int x, y, h, yy, xx;
    res = '0;
    x = c % w;
    y = c / w;
    h = n / w;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
        yy = y + rr - 1;
        xx = x + cc - 1;
        if (yy >= 0 && yy < h && xx >= 0 && xx < w)
          res[8*(3*rr+cc) +: 8] = img[yy*w + xx];
      end
    end
    return res;
  endfunction

  task automatic observe(input string nm, input int c, input int w, input int n);
    logic [1:0] et;
    et = (c % w == w - 1) ? DATA_TAG1 : DATA_TAG0;
    check({nm, "_tag"}, 72'(tag_out), 72'(et));
    check({nm, "_win"}, window_out, model_win(c, w, n));
    cap_win.push_back(window_out);
    cap_tag.push_back(tag_out);
  endtask

  task automatic run_image(input string nm, input int w, input int n,
                           input bit bubbles, input bit mess, input bit abort);
    int e, busy_cycles, exp_busy, nb;
    logic [1:0] t;
    e = 0;
    busy_cycles = 0;
    cap_win.delete();
    cap_tag.delete();
    image_width = 10'(w);
    for (int k = 0; k < n; k++) begin
      if (bubbles) begin
        nb = int'($urandom_range(1, 2));
        for (int b = 0; b < nb; b++) begin
          drive(INVALID_TAG, 8'($urandom));
          check({nm, "_bubble"}, 72'(tag_out), 72'(INVALID_TAG));
        end
      end
      t = (k % w == w - 1) ? DATA_TAG1 : DATA_TAG0;
      if (mess && $urandom_range(0, 3) == 0)
        t = ($urandom_range(0, 1) == 1) ? DATA_TAG1 : DATA_TAG0;
      drive(t, img[k]);
      if (k == 0) image_width = 10'($urandom_range(2, 1023));
      if (k >= w + 1) begin
        observe(nm, e, w, n);
        e++;
      end else begin
        check({nm, "_fill"}, 72'(tag_out), 72'(INVALID_TAG));
      end
    end

    drive(DATA_END_TAG, 8'($urandom));
    check({nm, "_end_tag"}, 72'(tag_out), 72'(INVALID_TAG));
    check({nm, "_end_busy"}, 72'(busy), 72'(1));
    exp_busy = (n - e) + ((n < w + 1) ? (w + 1 - n) : 0);

    while (busy === 1'b1 && busy_cycles < 2000) begin
      drive(2'($urandom), 8'($urandom));
      busy_cycles++;
      if (tag_out !== INVALID_TAG) begin
        if (e < n) observe(nm, e, w, n);
        else check({nm, "_extra"}, 72'(tag_out), 72'(INVALID_TAG));
        e++;
      end
      if (abort && busy_cycles == 1) begin
        reflesh = 1'b1;
        drive(DATA_TAG0, 8'hff);
        reflesh = 1'b0;
        check({nm, "_abort_tag"}, 72'(tag_out), 72'(INVALID_TAG));
        check({nm, "_abort_busy"}, 72'(busy), 72'(0));
        return;
      end
    end

    last_busy = busy_cycles;
    check({nm, "_busy_len"}, 72'(busy_cycles), 72'(exp_busy));
    check({nm, "_count"}, 72'(e), 72'(n));
    drive(DATA_TAG0, 8'($urandom));
    check({nm, "_end_out"}, 72'(tag_out), 72'(DATA_END_TAG));
    check({nm, "_done_busy"}, 72'(busy), 72'(0));
    drive(DATA_TAG1, 8'($urandom));
    check({nm, "_after_end"}, 72'(tag_out), 72'(INVALID_TAG));
    drive(DATA_END_TAG, 8'($urandom));
    check({nm, "_done_idle"}, 72'(tag_out), 72'(INVALID_TAG));
  endtask

  initial begin
    int w, h;
    reset       = 1'b1;
    reflesh     = 1'b0;
    image_width = 10'd4;
    data_in     = {INVALID_TAG, 8'h00};
    tick();
    tick();
    check("reset_win", window_out, 72'd0);
    check("reset_tag", 72'(tag_out), 72'(INVALID_TAG));
    check("reset_busy", 72'(busy), 72'(0));
    reset = 1'b0;

    // Basic 4x3 image of values 1..12
    for (int k = 0; k < 12; k++) img[k] = 8'(k + 1);
    run_image("basic", 4, 12, 1'b0, 1'b0, 1'b0);
    check("basic_first", cap_win[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    check("basic_first_tag", 72'(cap_tag[0]), 72'(DATA_TAG0));
    check("basic_centre11", cap_win[5], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    check("basic_last", cap_win[11], pack9(7, 8, 0, 11, 12, 0, 0, 0, 0));
    check("basic_last_tag", 72'(cap_tag[11]), 72'(DATA_TAG1));
    check("basic_busy5", 72'(last_busy), 72'(5));
    ref_win = cap_win;

    // Same image with bubbles between every pixel
    pulse_reflesh();
    run_image("bubble", 4, 12, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) check("bubble_same", cap_win[k], ref_win[k]);

    // Single row, W=3
    pulse_reflesh();
    img[0] = 8'd1; img[1] = 8'd2; img[2] = 8'd3;
    run_image("row", 3, 3, 1'b0, 1'b0, 1'b0);
    check("row_w0", cap_win[0], pack9(0, 0, 0, 0, 1, 2, 0, 0, 0));
    check("row_w1", cap_win[1], pack9(0, 0, 0, 1, 2, 3, 0, 0, 0));
    check("row_w2", cap_win[2], pack9(0, 0, 0, 2, 3, 0, 0, 0, 0));

    // Reflesh during the second flush cycle, then a fresh W=2 image
    pulse_reflesh();
    for (int k = 0; k < 12; k++) img[k] = 8'(k + 1);
    run_image("midflush", 4, 12, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) img[k] = 8'($urandom_range(1, 255));
    run_image("after", 2, 4, 1'b0, 1'b0, 1'b0);
    check("after_windows", 72'(cap_win.size()), 72'(4));

    // Reset in the middle of an image
    image_width = 10'd5;
    drive(DATA_TAG0, 8'h11);
    drive(DATA_TAG0, 8'h22);
    reset = 1'b1;
    drive(DATA_TAG0, 8'h33);
    reset = 1'b0;
    check("midreset_tag", 72'(tag_out), 72'(INVALID_TAG));
    check("midreset_busy", 72'(busy), 72'(0));
    check("midreset_win", window_out, 72'd0);

    // Randomised images with bubbles and misplaced row-end tags
    for (int it = 0; it < 6; it++) begin
      w = int'($urandom_range(2, 8));
      h = int'($urandom_range(1, 5));
      for (int k = 0; k < w * h; k++) img[k] = 8'($urandom);
      pulse_reflesh();
      run_image("rand", w, w * h, 1'b1, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
